// File: rtl/rf_bank_arbiter.sv
// Register-file read/write scheduler: per-bank round-robin read arbitration
// with writeback priority and same-register slot merging.
module rf_bank_arbiter #(
  parameter int NUM_OC = 8,
  parameter int REG_W  = 5,
  parameter int DATA_W = 256,
  localparam int NE = 2 * NUM_OC,
  localparam int IW = $clog2(NE),
  localparam int RW = REG_W - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OC-1:0]       alloc_valid,
  input  logic [NE-1:0]           alloc_src_valid,
  input  logic [NE*REG_W-1:0]     alloc_reg,
  output logic [NUM_OC-1:0]       alloc_ready,
  output logic [NE-1:0]           grant,
  input  logic                    wb_valid,
  input  logic [REG_W-1:0]        wb_reg,
  input  logic [7:0]              wb_mask,
  input  logic [DATA_W-1:0]       wb_data,
  output logic [RW-1:0]           RF_Addr_0,
  output logic [RW-1:0]           RF_Addr_1,
  output logic [RW-1:0]           RF_Addr_2,
  output logic [RW-1:0]           RF_Addr_3,
  output logic                    RF_WR_0,
  output logic                    RF_WR_1,
  output logic                    RF_WR_2,
  output logic                    RF_WR_3,
  output logic [7:0]              RF_WR_MASK,
  output logic [DATA_W-1:0]       WriteData,
  output logic [IW-1:0]           ocid_out_0,
  output logic [IW-1:0]           ocid_out_1,
  output logic [IW-1:0]           ocid_out_2,
  output logic [IW-1:0]           ocid_out_3,
  output logic                    same_0,
  output logic                    same_1,
  output logic                    same_2,
  output logic                    same_3
);

  logic [NE-1:0]     pend_q, pend_d;
  logic [REG_W-1:0]  rnum_q [NE];
  logic [REG_W-1:0]  rnum_d [NE];
  logic [IW-1:0]     ptr_q [4];
  logic [IW-1:0]     ptr_d [4];
  logic [RW-1:0]     addr_q [4];
  logic [RW-1:0]     addr_d [4];
  logic [IW-1:0]     ocid_q [4];
  logic [IW-1:0]     ocid_d [4];
  logic [3:0]        wr_q, wr_d;
  logic [3:0]        same_q, same_d;
  logic [NE-1:0]     grant_q, grant_d;
  logic [7:0]        mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    for (int i = 0; i < NUM_OC; i++) begin
      alloc_ready[i] = ~(pend_q[2*i] | pend_q[2*i+1]);
    end
  end

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] win;
    logic [IW-1:0] mate;
    pend_d  = pend_q;
    rnum_d  = rnum_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    ocid_d  = ocid_q;
    wr_d    = '0;
    same_d  = '0;
    grant_d = '0;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    found   = 1'b0;
    idx     = '0;
    win     = '0;
    mate    = '0;
    for (int b = 0; b < 4; b++) begin
      found = 1'b0;
      win   = '0;
      if (wb_valid && wb_reg[1:0] == 2'(b)) begin
        wr_d[b]   = 1'b1;
        addr_d[b] = wb_reg[REG_W-1:2];
      end else begin
        for (int k = 0; k < NE; k++) begin
          idx  = ptr_q[b] + IW'(k);
          mate = {idx[IW-1:1], 1'b0};
          // slot1 sharing slot0's register rides along with slot0
          if (!found && pend_q[idx] && rnum_q[idx][1:0] == 2'(b) &&
              !(idx[0] && pend_q[mate] && rnum_q[mate] == rnum_q[idx])) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          mate          = {win[IW-1:1], 1'b1};
          grant_d[win]  = 1'b1;
          pend_d[win]   = 1'b0;
          addr_d[b]     = rnum_q[win][REG_W-1:2];
          ocid_d[b]     = win;
          ptr_d[b]      = win + IW'(1);
          if (!win[0] && pend_q[mate] && rnum_q[mate] == rnum_q[win]) begin
            grant_d[mate] = 1'b1;
            pend_d[mate]  = 1'b0;
            same_d[b]     = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_OC; i++) begin
      if (alloc_valid[i] && alloc_ready[i]) begin
        for (int s = 0; s < 2; s++) begin
          if (alloc_src_valid[2*i+s]) begin
            pend_d[2*i+s] = 1'b1;
            rnum_d[2*i+s] = alloc_reg[(2*i+s)*REG_W +: REG_W];
          end
        end
      end
    end
    if (wb_valid) begin
      mask_d  = wb_mask;
      wdata_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      wr_q    <= '0;
      same_q  <= '0;
      grant_q <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      for (int e = 0; e < NE; e++) rnum_q[e] <= '0;
      for (int b = 0; b < 4; b++) begin
        ptr_q[b]  <= '0;
        addr_q[b] <= '0;
        ocid_q[b] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      rnum_q  <= rnum_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      ocid_q  <= ocid_d;
      wr_q    <= wr_d;
      same_q  <= same_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
    end
  end

  assign grant      = grant_q;
  assign RF_Addr_0  = addr_q[0];
  assign RF_Addr_1  = addr_q[1];
  assign RF_Addr_2  = addr_q[2];
  assign RF_Addr_3  = addr_q[3];
  assign RF_WR_0    = wr_q[0];
  assign RF_WR_1    = wr_q[1];
  assign RF_WR_2    = wr_q[2];
  assign RF_WR_3    = wr_q[3];
  assign RF_WR_MASK = mask_q;
  assign WriteData  = wdata_q;
  assign ocid_out_0 = ocid_q[0];
  assign ocid_out_1 = ocid_q[1];
  assign ocid_out_2 = ocid_q[2];
  assign ocid_out_3 = ocid_q[3];
  assign same_0     = same_q[0];
  assign same_1     = same_q[1];
  assign same_2     = same_q[2];
  assign same_3     = same_q[3];

endmodule
